seg7_capture: RTL and testbench

Receive side of the multiplexed hex seven-segment display bus. The block samples the `disp_seg`/`disp_an` lines driven by the display scanner or by an external board, and debounces each digit. It decodes each segment pattern back to a hex nibble and reassembles the full 32-bit displayed value. It sits in the test and bring-up path, for example in loopback checking of the display driver or reading a front-panel display into a register.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 14 +
 rtl/seg7_capture.sv | 136 +++++++++++++
 tb/tb_seg7_capture.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment constants, debounce states and pattern decode
package seg7_pkg;

  localparam int N_DIGITS = 8;
  localparam int NIB_W    = 4;

  // Index n holds the active-high pattern (bit0 = a .. bit6 = g) for hex digit n.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } deb_state_t;

  // Returns {ok, nibble}; an unknown pattern gives ok = 0 and nibble 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PAT[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational segment pattern to hex nibble decoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       ok_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    {ok_o, nibble_o} = seg_decode(seg_i);
  end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - synchronize, debounce and reassemble a multiplexed hex display bus
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  disp_seg,
  input  logic [7:0]  disp_an,
  output logic [31:0] number,
  output logic        valid,
  output logic        frame_error,
  output logic [7:0]  digit_seen
);

  localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

  logic [14:0] sync1_q, sync2_q, prev_q;
  deb_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        accept;
  logic        same;

  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  seen_q, seen_d;
  logic        flag_q, flag_d;
  logic [31:0] number_q, number_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  logic [7:0]  samp_an;
  logic [6:0]  samp_seg;
  logic        dec_ok;
  logic [3:0]  dec_nib;

  assign samp_an  = sync2_q[14:7];
  assign samp_seg = sync2_q[6:0];
  assign same     = (sync2_q == prev_q);

  seg7_decode u_decode (
    .seg_i    (samp_seg),
    .ok_o     (dec_ok),
    .nibble_o (dec_nib)
  );

  // cnt_d is the number of identical samples seen so far minus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        cnt_d = same ? cnt_q + 16'd1 : 16'd0;
        if (cnt_d == CNT_LAST) begin
          accept  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!same) begin
          state_d = ST_SETTLE;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    seen_d   = seen_q;
    flag_d   = flag_q;
    number_d = number_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    if (accept && (samp_an != 8'd0)) begin
      if ((samp_an & (samp_an - 8'd1)) == 8'd0) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (samp_an[i]) begin
            shadow_d[NIB_W*i +: NIB_W] = dec_ok ? dec_nib : 4'd0;
            seen_d[i] = 1'b1;
          end
        end
        if (!dec_ok) flag_d = 1'b1;
      end else begin
        flag_d = 1'b1;
      end
    end
    // Completion publishes and clears in one step so the next accept starts a fresh frame.
    if (seen_d == 8'hFF) begin
      number_d = shadow_d;
      valid_d  = 1'b1;
      ferr_d   = flag_d;
      seen_d   = 8'd0;
      flag_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      state_q  <= ST_SETTLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      seen_q   <= '0;
      flag_q   <= 1'b0;
      number_q <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= {disp_an, disp_seg};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
      flag_q   <= flag_d;
      number_q <= number_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign number      = number_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;
  assign digit_seen  = seen_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed vector bench for seg7_capture
module tb_seg7_capture;
  import seg7_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  disp_seg;
  logic [7:0]  disp_an;
  logic [31:0] number;
  logic        valid;
  logic        frame_error;
  logic [7:0]  digit_seen;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  logic [31:0] last_num = '0;
  logic        last_ferr = 1'b0;
  logic        loop_mode = 1'b0;
  logic [31:0] loop_val = '0;

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .disp_seg    (disp_seg),
    .disp_an     (disp_an),
    .number      (number),
    .valid       (valid),
    .frame_error (frame_error),
    .digit_seen  (digit_seen)
  );

  typedef struct {
    logic [31:0] value;
    int          bad_digit;
    bit          glitch;
    bit          blank;
    bit          multi;
    logic [31:0] exp_num;
    bit          exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      last_num  = number;
      last_ferr = frame_error;
      if (loop_mode) begin
        checks++;
        if (number !== loop_val) begin
          errors++;
          $display("FAIL loopback: got %h expected %h", number, loop_val);
        end
      end
    end
  end

  task automatic dwell(input logic [7:0] an, input logic [6:0] seg, input int n);
    disp_an  = an;
    disp_seg = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v, input string name);
    int          v0;
    logic [3:0]  nib;
    logic [6:0]  seg;
    logic [7:0]  mask;
    v0 = vcount;
    for (int d = 0; d < 8; d++) begin
      nib  = v.value[4*d +: 4];
      seg  = (d == v.bad_digit) ? 7'h00 : SEG_PAT[nib];
      mask = 8'((16'd1 << (d + 1)) - 16'd1);
      dwell(8'(1 << d), seg, 10);
      if (v.glitch) dwell(8'(1 << d), seg ^ 7'h7F, 2);
      if ((v.blank || v.multi) && d < 7) begin
        check({name, " seen"}, {24'd0, digit_seen}, {24'd0, mask});
        if (v.multi && d == 2) dwell(8'h03, SEG_PAT[1], 10);
        if (v.blank) dwell(8'h00, 7'h00, 10);
        check({name, " seen after extra dwell"}, {24'd0, digit_seen}, {24'd0, mask});
      end
    end
    check({name, " valid count"}, 32'(vcount - v0), 32'd1);
    check({name, " number"}, last_num, v.exp_num);
    check({name, " frame_error"}, {31'd0, last_ferr}, {31'd0, v.exp_ferr});
  endtask

  vec_t vecs[8];
  vec_t rv;
  int   v0;

  initial begin
    vecs[0] = '{32'h89ABCDEF, -1, 0, 0, 0, 32'h89ABCDEF, 0};
    vecs[1] = '{32'h89ABCDEF, -1, 1, 0, 0, 32'h89ABCDEF, 0};
    vecs[2] = '{32'h12345678,  3, 0, 0, 0, 32'h12340678, 1};
    vecs[3] = '{32'hFEDCBA98, -1, 0, 0, 0, 32'hFEDCBA98, 0};
    vecs[4] = '{32'hDEADBEEF, -1, 0, 1, 0, 32'hDEADBEEF, 0};
    vecs[5] = '{32'h01234567, -1, 0, 1, 1, 32'h01234567, 1};
    vecs[6] = '{32'hA5A5A5A5,  7, 0, 0, 0, 32'h05A5A5A5, 1};
    vecs[7] = '{32'hCAFEF00D, -1, 1, 1, 0, 32'hCAFEF00D, 0};

    reset    = 1'b1;
    disp_an  = 8'h00;
    disp_seg = 7'h00;
    repeat (3) @(negedge clk);
    check("reset number", number, 32'd0);
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset frame_error", {31'd0, frame_error}, 32'd0);
    check("reset digit_seen", {24'd0, digit_seen}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Reset after five digits discards the partial frame.
    v0 = vcount;
    for (int d = 0; d < 5; d++) dwell(8'(1 << d), SEG_PAT[4'(d + 1)], 10);
    check("midframe seen", {24'd0, digit_seen}, 32'h1F);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset seen", {24'd0, digit_seen}, 32'd0);
    check("post-reset number", number, 32'd0);
    reset = 1'b0;
    rv = '{32'h76543210, -1, 0, 0, 0, 32'h76543210, 0};
    run_frame(rv, "after reset");
    check("no valid from partial frame", 32'(vcount - v0), 32'd1);

    // Loopback from a scanner model running at a short dwell.
    v0 = vcount;
    loop_mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      loop_val = (k == 0) ? 32'h13579BDF : 32'h2468ACE0;
      for (int s = 0; s < 3; s++) begin
        for (int d = 0; d < 8; d++) dwell(8'(1 << d), SEG_PAT[loop_val[4*d +: 4]], 8);
      end
    end
    loop_mode = 1'b0;
    check("loopback valid count", 32'(vcount - v0), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
